// File: rtl/condicionador_botoes_if.sv
// Button conditioner bus: raw button levels and enable in, conditioned
// vector, press/release pulses, chord flag and debug state out.
interface condicionador_botoes_if #(
    parameter int N_BOTOES = 7
);
    logic [N_BOTOES-1:0] botoes_raw;
    logic                habilita;
    logic [N_BOTOES-1:0] botoes;
    logic                pressionado;
    logic                solto;
    logic                multiplo;
    logic [2:0]          db_estado;

    // Game side: drives the raw buttons and enable, consumes the clean result.
    modport master (
        output botoes_raw,
        output habilita,
        input  botoes,
        input  pressionado,
        input  solto,
        input  multiplo,
        input  db_estado
    );

    // Conditioner side.
    modport slave (
        input  botoes_raw,
        input  habilita,
        output botoes,
        output pressionado,
        output solto,
        output multiplo,
        output db_estado
    );
endinterface

// File: rtl/condicionador_botoes.sv
// Note-button input conditioner: 2-flop synchroniser, debounce and
// single-button enforcement, with one-cycle press/release pulses.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// OCIOSO         | no press accepted; waits for a button while habilita=1
// FILTRA_PRESS   | candidate vector must stay stable DEBOUNCE_CICLOS samples
// PRESSIONADO    | one-hot press accepted and driven on botoes
// FILTRA_SOLTURA | buttons changed; zero must stay stable to accept release
// ESPERA_SOLTURA | chord rejected; waits for a stable all-released input
module condicionador_botoes #(
    parameter int N_BOTOES        = 7,
    parameter int DEBOUNCE_CICLOS = 20,
    parameter int CW              = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    condicionador_botoes_if.slave  bus
);

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        FILTRA_PRESS   = 3'd1,
        PRESSIONADO    = 3'd2,
        FILTRA_SOLTURA = 3'd3,
        ESPERA_SOLTURA = 3'd4
    } estado_t;

    localparam logic [CW-1:0]       CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [N_BOTOES-1:0] ZERO    = '0;
    localparam logic [N_BOTOES-1:0] UM      = N_BOTOES'(1);

    estado_t             estado_q, estado_d;
    logic [N_BOTOES-1:0] sync1_q, sync1_d;
    logic [N_BOTOES-1:0] s_q, s_d;
    logic [N_BOTOES-1:0] cand_q, cand_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_BOTOES-1:0] botoes_q, botoes_d;
    logic                pressionado_q, pressionado_d;
    logic                solto_q, solto_d;
    logic                multiplo_q, multiplo_d;
    logic                cand_um_bit;

    // Exactly one bit set in the candidate (it is known nonzero when used).
    assign cand_um_bit = (cand_q != ZERO) && ((cand_q & (cand_q - UM)) == ZERO);

    // Register every flop; synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= OCIOSO;
            sync1_q       <= '0;
            s_q           <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            botoes_q      <= '0;
            pressionado_q <= 1'b0;
            solto_q       <= 1'b0;
            multiplo_q    <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            sync1_q       <= sync1_d;
            s_q           <= s_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            botoes_q      <= botoes_d;
            pressionado_q <= pressionado_d;
            solto_q       <= solto_d;
            multiplo_q    <= multiplo_d;
        end
    end

    // Synchroniser chain plus next-state, counter and output decisions.
    always_comb begin
        sync1_d       = bus.botoes_raw;
        s_d           = sync1_q;
        estado_d      = estado_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        botoes_d      = botoes_q;
        pressionado_d = 1'b0;
        solto_d       = 1'b0;
        multiplo_d    = multiplo_q;

        case (estado_q)
            OCIOSO: begin
                if ((s_q != ZERO) && bus.habilita) begin
                    cand_d   = s_q;
                    cnt_d    = '0;
                    estado_d = FILTRA_PRESS;
                end
            end

            FILTRA_PRESS: begin
                if (s_q == ZERO) begin
                    estado_d = OCIOSO;
                end else if (s_q != cand_q) begin
                    cand_d = s_q;
                    cnt_d  = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (cand_um_bit) begin
                    botoes_d      = cand_q;
                    pressionado_d = 1'b1;
                    estado_d      = PRESSIONADO;
                end else begin
                    multiplo_d = 1'b1;
                    cnt_d      = '0;
                    estado_d   = ESPERA_SOLTURA;
                end
            end

            PRESSIONADO: begin
                if (s_q != botoes_q) begin
                    cnt_d    = '0;
                    estado_d = FILTRA_SOLTURA;
                end
            end

            FILTRA_SOLTURA: begin
                if (s_q == botoes_q) begin
                    estado_d = PRESSIONADO;
                end else if (s_q != ZERO) begin
                    cnt_d = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    botoes_d = '0;
                    solto_d  = 1'b1;
                    estado_d = OCIOSO;
                end
            end

            ESPERA_SOLTURA: begin
                // cand tracks the previous sample so the release only counts
                // once zero has been seen stable, giving the same timing as
                // the press and release filters.
                cand_d = s_q;
                if ((s_q != ZERO) || (cand_q != ZERO)) begin
                    cnt_d = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    multiplo_d = 1'b0;
                    estado_d   = OCIOSO;
                end
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign bus.botoes      = botoes_q;
    assign bus.pressionado = pressionado_q;
    assign bus.solto       = solto_q;
    assign bus.multiplo    = multiplo_q;
    assign bus.db_estado   = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Scoreboard bench for the button conditioner (DEBOUNCE_CICLOS = 4).
// Expected output events are queued with their cycle when stimulus is
// driven; a monitor pops and compares each event the DUT produces.
module tb_condicionador_botoes;

    localparam int D = 4;

    localparam int EV_BOT   = 0;
    localparam int EV_PRESS = 1;
    localparam int EV_SOLTO = 2;
    localparam int EV_MULT  = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic clock;
    logic reset;
    int   cyc;
    int   vectors;
    int   miscompares;
    bit   mon_en;
    ev_t  evq[$];
    logic [6:0] botoes_prev;
    logic       mult_prev;

    condicionador_botoes_if #(.N_BOTOES(7)) bus ();

    condicionador_botoes #(
        .N_BOTOES        (7),
        .DEBOUNCE_CICLOS (D),
        .CW              (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic string ev_name(input int kind);
        case (kind)
            EV_BOT:   return "botoes";
            EV_PRESS: return "pressionado";
            EV_SOLTO: return "solto";
            default:  return "multiplo";
        endcase
    endfunction

    task automatic push_ev(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        evq.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int val);
        ev_t e;
        chk({ev_name(kind), "_expected"}, int'(evq.size() > 0), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            chk({ev_name(kind), "_kind"}, kind, e.kind);
            chk({ev_name(kind), "_cycle"}, cyc, e.cyc);
            chk({ev_name(kind), "_value"}, val, e.val);
        end
    endtask

    // Count edges and turn every output change into a scoreboard event.
    always @(posedge clock) begin
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            if (bus.botoes !== botoes_prev) got_ev(EV_BOT, int'(bus.botoes));
            if (bus.pressionado) got_ev(EV_PRESS, int'(bus.botoes));
            if (bus.solto) got_ev(EV_SOLTO, 0);
            if (bus.multiplo !== mult_prev) got_ev(EV_MULT, int'(bus.multiplo));
            if (bus.pressionado || bus.solto)
                chk("press_solto_exclusive", int'(bus.pressionado & bus.solto), 0);
            botoes_prev = bus.botoes;
            mult_prev   = bus.multiplo;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drive a level at a negedge; the following posedge is edge 0.
    task automatic drive_raw(input logic [6:0] v, output int c0);
        bus.botoes_raw = v;
        c0 = cyc + 1;
    endtask

    initial begin
        int c0;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        reset          = 1'b1;
        bus.habilita   = 1'b1;
        bus.botoes_raw = 7'b0;
        wait_cycles(3);

        chk("reset_botoes",      int'(bus.botoes), 0);
        chk("reset_pressionado", int'(bus.pressionado), 0);
        chk("reset_solto",       int'(bus.solto), 0);
        chk("reset_multiplo",    int'(bus.multiplo), 0);
        chk("reset_db_estado",   int'(bus.db_estado), 0);
        botoes_prev = 7'b0;
        mult_prev   = 1'b0;
        mon_en      = 1'b1;
        reset       = 1'b0;
        wait_cycles(3);

        // Clean one-hot press and release.
        drive_raw(7'b0001000, c0);
        push_ev(EV_BOT, c0 + D + 2, 7'b0001000);
        push_ev(EV_PRESS, c0 + D + 2, 7'b0001000);
        wait_cycles(30);
        chk("held_db_estado", int'(bus.db_estado), 2);
        chk("held_botoes", int'(bus.botoes), 7'b0001000);
        drive_raw(7'b0, c0);
        push_ev(EV_BOT, c0 + D + 2, 0);
        push_ev(EV_SOLTO, c0 + D + 2, 0);
        wait_cycles(15);

        // Bouncing contact: nothing until the level settles.
        for (int i = 0; i < 9; i++) begin
            drive_raw((i % 2 == 0) ? 7'b0000001 : 7'b0, c0);
            wait_cycles(1);
        end
        c0 = c0;
        push_ev(EV_BOT, c0 + D + 2, 7'b0000001);
        push_ev(EV_PRESS, c0 + D + 2, 7'b0000001);
        wait_cycles(15);
        drive_raw(7'b0, c0);
        push_ev(EV_BOT, c0 + D + 2, 0);
        push_ev(EV_SOLTO, c0 + D + 2, 0);
        wait_cycles(15);

        // Two-button chord is rejected and must be fully released.
        drive_raw(7'b0000011, c0);
        push_ev(EV_MULT, c0 + D + 2, 1);
        wait_cycles(20);
        chk("chord_db_estado", int'(bus.db_estado), 4);
        chk("chord_botoes", int'(bus.botoes), 0);
        drive_raw(7'b0, c0);
        push_ev(EV_MULT, c0 + D + 2, 0);
        wait_cycles(15);

        // Press while disabled, then enable with the button still held:
        // accepted on the fifth edge counting the one that samples habilita.
        bus.habilita = 1'b0;
        drive_raw(7'b1000000, c0);
        wait_cycles(20);
        chk("disabled_db_estado", int'(bus.db_estado), 0);
        chk("disabled_botoes", int'(bus.botoes), 0);
        bus.habilita = 1'b1;
        c0 = cyc + 1;
        push_ev(EV_BOT, c0 + D, 7'b1000000);
        push_ev(EV_PRESS, c0 + D, 7'b1000000);
        wait_cycles(15);
        drive_raw(7'b0, c0);
        push_ev(EV_BOT, c0 + D + 2, 0);
        push_ev(EV_SOLTO, c0 + D + 2, 0);
        wait_cycles(15);

        // Short dropout while held is a glitch; then reset mid-hold.
        drive_raw(7'b0100000, c0);
        push_ev(EV_BOT, c0 + D + 2, 7'b0100000);
        push_ev(EV_PRESS, c0 + D + 2, 7'b0100000);
        wait_cycles(15);
        drive_raw(7'b0, c0);
        wait_cycles(2);
        drive_raw(7'b0100000, c0);
        wait_cycles(10);
        chk("glitch_botoes", int'(bus.botoes), 7'b0100000);
        chk("glitch_db_estado", int'(bus.db_estado), 2);
        reset = 1'b1;
        drive_raw(7'b0, c0);
        push_ev(EV_BOT, c0, 0);
        @(posedge clock);
        #2;
        chk("midreset_botoes",      int'(bus.botoes), 0);
        chk("midreset_pressionado", int'(bus.pressionado), 0);
        chk("midreset_solto",       int'(bus.solto), 0);
        chk("midreset_multiplo",    int'(bus.multiplo), 0);
        chk("midreset_db_estado",   int'(bus.db_estado), 0);
        @(negedge clock);
        reset = 1'b0;
        wait_cycles(15);

        chk("events_left_over", evq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
